mul_seq_16bit: RTL and testbench

Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier, built as the consumer of the `adder_16bit` combinational stage. The block instantiates one `adder_16bit` and iterates through it once per clock: it drives the adder's `X`/`Y` inputs and captures `Z` and `carry` as the new partial product. It accepts operands with a start/busy/done handshake and sits in the datapath beside the adder, feeding results to the register file.

---
 rtl/mul_seq_16bit.sv | 136 +++++++++++++
 tb/tb_mul_seq_16bit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq_16bit.sv
// rtl/mul_seq_16bit.sv - sequential 16x16 shift-and-add multiplier built around adder_16bit

// Combinational 16-bit adder stage with status flags.
module adder_16bit (
    input  logic [15:0] X,
    input  logic [15:0] Y,
    output logic [15:0] Z,
    output logic        carry,
    output logic        sign,
    output logic        zero,
    output logic        parity,
    output logic        overflow
);

    // Unsigned sum with carry-out, plus flags derived from the 16-bit result.
    always_comb begin
        {carry, Z} = {1'b0, X} + {1'b0, Y};
        sign       = Z[15];
        zero       = (Z == 16'h0000);
        parity     = ^Z;
        overflow   = (X[15] == Y[15]) && (Z[15] != X[15]);
    end

endmodule

// Unsigned multiplier: one adder pass per clock, 16 passes per product.
module mul_seq_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    output logic [31:0] P,
    output logic        busy,
    output logic        done,
    output logic        zero,
    output logic        wide
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [15:0] a_reg;
    logic [15:0] h_reg;
    logic [15:0] l_reg;
    logic [4:0]  cnt;

    logic [15:0] sum;
    logic        sum_carry;
    logic        unused_sign;
    logic        unused_zero;
    logic        unused_parity;
    logic        unused_overflow;

    logic [15:0] h_next;
    logic [15:0] l_next;
    logic        last_iter;

    // High partial product plus latched multiplicand; only Z and carry are consumed.
    adder_16bit u_adder (
        .X        (h_reg),
        .Y        (a_reg),
        .Z        (sum),
        .carry    (sum_carry),
        .sign     (unused_sign),
        .zero     (unused_zero),
        .parity   (unused_parity),
        .overflow (unused_overflow)
    );

    // Next partial product: add-and-shift when the current multiplier bit is set,
    // shift only otherwise. The adder carry becomes the MSB, so nothing is lost.
    always_comb begin
        h_next = {1'b0, h_reg[15:1]};
        l_next = {h_reg[0], l_reg[15:1]};
        if (l_reg[0]) begin
            h_next = {sum_carry, sum[15:1]};
            l_next = {sum[0], l_reg[15:1]};
        end
        last_iter = (cnt == 5'd15);
    end

    // Control state, operand registers and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= 16'h0000;
            h_reg <= 16'h0000;
            l_reg <= 16'h0000;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= X;
                        h_reg <= 16'h0000;
                        l_reg <= Y;
                        cnt   <= 5'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    h_reg <= h_next;
                    l_reg <= l_next;
                    cnt   <= cnt + 5'd1;
                    if (last_iter) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result register and flags update only on the completing edge; done is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P    <= 32'h0000_0000;
            zero <= 1'b1;
            wide <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN && last_iter) begin
                P    <= {h_next, l_next};
                zero <= ({h_next, l_next} == 32'h0000_0000);
                wide <= (h_next != 16'h0000);
                done <= 1'b1;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mul_seq_16bit.sv
// tb/tb_mul_seq_16bit.sv - directed self-checking bench for mul_seq_16bit

module tb_mul_seq_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic [31:0] P;
    logic        busy;
    logic        done;
    logic        zero;
    logic        wide;

    int errors = 0;
    int checks = 0;
    int nb;
    int nd;
    int hold_bad;

    mul_seq_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .P     (P),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .wide  (wide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_P"},    P,    32'h0);
        check({tag, "_busy"}, busy, 32'h0);
        check({tag, "_done"}, done, 32'h0);
        check({tag, "_zero"}, zero, 32'h1);
        check({tag, "_wide"}, wide, 32'h0);
    endtask

    // Issue one multiply, then watch busy/done until completion (bounded).
    task automatic run_mul(input logic [15:0] x, input logic [15:0] y,
                           input logic [31:0] ep, input logic ez, input logic ew,
                           input string tag);
        int bcnt;
        int dcnt;
        bit got;
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        X = 16'($urandom);
        Y = 16'($urandom);
        bcnt = 0; dcnt = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'h1);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
        check({tag, "_busy_at_done"}, busy, 32'h0);
        check({tag, "_P"}, P, ep);
        check({tag, "_zero"}, zero, 32'(ez));
        check({tag, "_wide"}, wide, 32'(ew));
        @(negedge clk);
        check({tag, "_done_single"}, done, 32'h0);
        check({tag, "_P_hold"}, P, ep);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        X = 16'h0;
        Y = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_mul(16'd3,    16'd5,    32'h0000_000F, 1'b0, 1'b0, "m3x5");
        run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b1, "mmax");
        run_mul(16'h1234, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, "mYzero");
        run_mul(16'h0000, 16'hFFFF, 32'h0000_0000, 1'b1, 1'b0, "mXzero");

        // 7*9 with starts during busy that must be ignored
        @(negedge clk);
        X = 16'd7; Y = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; nd = 0;
        for (int j = 0; j < 16; j++) begin
            if (busy) nb++;
            if (done) nd++;
            if (j == 3 || j == 10) begin
                start = 1'b1; X = 16'd2; Y = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_no_early_done", 32'(nd), 32'd0);
        check("ign_busy_cycles", 32'(nb), 32'd16);
        check("ign_done", done, 32'h1);
        check("ign_busy_at_done", busy, 32'h0);
        check("ign_P", P, 32'h0000_003F);

        // start in the done cycle: accepted at the next edge, P holds old value
        X = 16'h0100; Y = 16'h0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        X = 16'h0; Y = 16'h0;
        check("b2b_busy", busy, 32'h1);
        check("b2b_done_fell", done, 32'h0);
        check("b2b_P_old", P, 32'h0000_003F);
        hold_bad = 0;
        for (int j = 1; j < 16; j++) begin
            @(negedge clk);
            if (P !== 32'h0000_003F || busy !== 1'b1 || done !== 1'b0) hold_bad++;
        end
        check("b2b_hold", 32'(hold_bad), 32'd0);
        @(negedge clk);
        check("b2b_done", done, 32'h1);
        check("b2b_P", P, 32'h0001_0000);
        check("b2b_wide", wide, 32'h1);
        check("b2b_zero", zero, 32'h0);

        // asynchronous reset mid-multiply
        @(negedge clk);
        X = 16'hFFFF; Y = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_pre_busy", busy, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        nd = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done) nd++;
            if (j == 2) rst_n = 1'b1;
        end
        check("rst_no_done", 32'(nd), 32'd0);
        check("rst_idle_busy", busy, 32'h0);
        check("rst_P_cleared", P, 32'h0);

        run_mul(16'd6, 16'd7, 32'h0000_002A, 1'b0, 1'b0, "m6x7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
